// File: rtl/alu_issue_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : alu_issue_ctrl
// Purpose : Issue/retire stage around a combinational 32-bit ALU. It holds the
//           ALU operands stable, samples F/Co after a settle interval, and
//           chains Co into the next Ci.
// Revision: 1.0
// ============================================================================
module alu_issue_ctrl #(
    parameter int SETTLE_CYCLES = 1,
    parameter int CNT_W         = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [31:0]      cmd_a,
    input  logic [31:0]      cmd_b,
    input  logic [2:0]       cmd_sel,
    input  logic             cmd_ci,
    input  logic             cmd_chain,
    output logic [31:0]      alu_a,
    output logic [31:0]      alu_b,
    output logic             alu_s0,
    output logic             alu_s1,
    output logic             alu_s2,
    output logic             alu_ci,
    input  logic [31:0]      alu_f,
    input  logic             alu_co,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [31:0]      res_f,
    output logic             res_co,
    output logic             res_zero,
    output logic             carry_q,
    output logic [CNT_W-1:0] ops_done
);

    // The settle counter runs from SETTLE_CYCLES-1 down to 0.
    localparam int CW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_LOAD = CW'(SETTLE_CYCLES - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EXEC = 2'd1,
        S_HOLD = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [31:0]      a_q, a_d, b_q, b_d, f_q, f_d;
    logic [2:0]       sel_q, sel_d;
    logic             ci_q, ci_d, co_q, co_d, zero_q, zero_d, carry_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [CNT_W-1:0] ops_q, ops_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            a_q     <= '0;
            b_q     <= '0;
            sel_q   <= '0;
            ci_q    <= 1'b0;
            cnt_q   <= '0;
            f_q     <= '0;
            co_q    <= 1'b0;
            zero_q  <= 1'b0;
            carry_q <= 1'b0;
            ops_q   <= '0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            sel_q   <= sel_d;
            ci_q    <= ci_d;
            cnt_q   <= cnt_d;
            f_q     <= f_d;
            co_q    <= co_d;
            zero_q  <= zero_d;
            carry_q <= carry_d;
            ops_q   <= ops_d;
        end
    end

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        sel_d   = sel_q;
        ci_d    = ci_q;
        cnt_d   = cnt_q;
        f_d     = f_q;
        co_d    = co_q;
        zero_d  = zero_q;
        carry_d = carry_q;
        ops_d   = ops_q;
        case (state_q)
            S_IDLE: begin
                if (cmd_valid) begin
                    a_d     = cmd_a;
                    b_d     = cmd_b;
                    sel_d   = cmd_sel;
                    ci_d    = cmd_chain ? carry_q : cmd_ci;
                    cnt_d   = CNT_LOAD;
                    state_d = S_EXEC;
                end
            end
            S_EXEC: begin
                if (cnt_q == '0) begin
                    f_d     = alu_f;
                    co_d    = alu_co;
                    zero_d  = (alu_f == 32'd0);
                    state_d = S_HOLD;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            S_HOLD: begin
                // Carry only moves on retirement so chained ops see the last retired Co.
                if (res_ready) begin
                    carry_d = co_q;
                    ops_d   = ops_q + CNT_W'(1);
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign cmd_ready = (state_q == S_IDLE) && !rst;
    assign res_valid = (state_q == S_HOLD);
    assign alu_a     = a_q;
    assign alu_b     = b_q;
    assign alu_s0    = sel_q[0];
    assign alu_s1    = sel_q[1];
    assign alu_s2    = sel_q[2];
    assign alu_ci    = ci_q;
    assign res_f     = f_q;
    assign res_co    = co_q;
    assign res_zero  = zero_q;
    assign ops_done  = ops_q;

endmodule
`default_nettype wire
